// File: rtl/dvp_capture_pack_if.sv
// DVP sensor inputs and packed-word outputs of one camera capture channel.
// The sensor model or upstream pad logic drives the master side; the capture block is the slave.
interface dvp_capture_pack_if;
  logic        i_cam_vsync;
  logic        i_cam_href;
  logic [7:0]  i_cam_data;
  logic        o_cam_data_rst;
  logic        o_cam_data_valid;
  logic [31:0] o_cam_data_32;
  logic [7:0]  o_frame_cnt;
  logic        o_err;

  modport master (
    output i_cam_vsync, i_cam_href, i_cam_data,
    input  o_cam_data_rst, o_cam_data_valid, o_cam_data_32, o_frame_cnt, o_err
  );

  modport slave (
    input  i_cam_vsync, i_cam_href, i_cam_data,
    output o_cam_data_rst, o_cam_data_valid, o_cam_data_32, o_frame_cnt, o_err
  );
endinterface

// File: rtl/dvp_capture_pack.sv
// OV5640 DVP capture: skips settling frames, packs RGB565 byte pairs into 32-bit words
// (two pixels per word) and emits a frame-start reset pulse for the write FIFO.
module dvp_capture_pack #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FRAME_SKIP = 10,
  parameter int RST_LEN    = 8
) (
  input  logic              i_cam_pclk,
  input  logic              i_sys_rst,
  dvp_capture_pack_if.slave cam_if
);
  localparam int PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam int SKIP_W = (FRAME_SKIP < 2) ? 1 : $clog2(FRAME_SKIP + 1);
  localparam int RST_W  = (RST_LEN < 2) ? 1 : $clog2(RST_LEN + 1);

  localparam logic [1:0] ST_SKIP    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic              vsync_d1_q, vsync_d2_q, href_d1_q, href_d2_q;
  logic [7:0]        data_d1_q;
  logic [1:0]        state_q, state_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic              rst_pulse_q, rst_pulse_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       data_32_q, data_32_d;
  logic              valid_q, valid_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;

  logic vs_rise, line_end, line_open, line_full;

  assign vs_rise   = vsync_d1_q & ~vsync_d2_q;
  assign line_end  = href_d2_q & ~href_d1_q;
  assign line_open = (line_cnt_q < LINE_W'(V_ACTIVE));
  assign line_full = (pix_cnt_q == PIX_W'(H_ACTIVE));

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    rst_cnt_d   = rst_cnt_q;
    rst_pulse_d = rst_pulse_q;
    byte_idx_d  = byte_idx_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    word_d      = word_q;
    data_32_d   = data_32_q;
    valid_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;

    case (state_q)
      ST_SKIP: begin
        if (FRAME_SKIP == 0) begin
          state_d = ST_ARM;
        end else if (vs_rise) begin
          if (skip_cnt_q == SKIP_W'(FRAME_SKIP - 1)) state_d = ST_ARM;
          else skip_cnt_d = skip_cnt_q + SKIP_W'(1);
        end
      end
      ST_ARM: begin
        if (vs_rise) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // A vsync edge closes the running frame; a cut-off line or short frame is an error.
        if (vs_rise) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (href_d1_q || (byte_idx_q != 2'd0) || line_open) err_d = 1'b1;
        end
      end
      default: state_d = ST_SKIP;
    endcase

    if ((state_q != ST_SKIP) && vs_rise) begin
      rst_pulse_d = 1'b1;
      rst_cnt_d   = RST_W'(RST_LEN - 1);
    end else if (rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - RST_W'(1);
    end else begin
      rst_pulse_d = 1'b0;
    end

    if ((state_q != ST_CAPTURE) || vs_rise || rst_pulse_q) begin
      byte_idx_d = 2'd0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
    end else if (line_end) begin
      if (line_open) begin
        if ((byte_idx_q != 2'd0) || !line_full) err_d = 1'b1;
        line_cnt_d = line_cnt_q + LINE_W'(1);
      end
      byte_idx_d = 2'd0;
      pix_cnt_d  = '0;
    end else if (href_d1_q && line_open) begin
      if (line_full) begin
        err_d = 1'b1;
      end else begin
        word_d     = {word_q[15:0], data_d1_q};
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q[0]) pix_cnt_d = pix_cnt_q + PIX_W'(1);
        if (byte_idx_q == 2'd3) begin
          data_32_d = {word_q, data_d1_q};
          valid_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_cam_pclk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      vsync_d1_q  <= 1'b0;
      vsync_d2_q  <= 1'b0;
      href_d1_q   <= 1'b0;
      href_d2_q   <= 1'b0;
      data_d1_q   <= 8'd0;
      state_q     <= ST_SKIP;
      skip_cnt_q  <= '0;
      rst_cnt_q   <= '0;
      rst_pulse_q <= 1'b0;
      byte_idx_q  <= 2'd0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      word_q      <= 24'd0;
      data_32_q   <= 32'd0;
      valid_q     <= 1'b0;
      frame_cnt_q <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      vsync_d1_q  <= cam_if.i_cam_vsync;
      vsync_d2_q  <= vsync_d1_q;
      href_d1_q   <= cam_if.i_cam_href;
      href_d2_q   <= href_d1_q;
      data_d1_q   <= cam_if.i_cam_data;
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      rst_pulse_q <= rst_pulse_d;
      byte_idx_q  <= byte_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      word_q      <= word_d;
      data_32_q   <= data_32_d;
      valid_q     <= valid_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign cam_if.o_cam_data_rst   = rst_pulse_q;
  assign cam_if.o_cam_data_valid = valid_q;
  assign cam_if.o_cam_data_32    = data_32_q;
  assign cam_if.o_frame_cnt      = frame_cnt_q;
  assign cam_if.o_err            = err_q;
endmodule

// File: tb/tb_dvp_capture_pack.sv
// Directed bench for dvp_capture_pack on a reduced 8x4 frame with a 2-frame skip.
`timescale 1ns/1ps
module tb_dvp_capture_pack;
  localparam int H    = 8;
  localparam int V    = 4;
  localparam int SKIP = 2;
  localparam int RLEN = 8;
  localparam int WPL  = H / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dvp_capture_pack_if dif ();

  dvp_capture_pack #(
    .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_SKIP(SKIP), .RST_LEN(RLEN)
  ) dut (
    .i_cam_pclk(clk),
    .i_sys_rst (rst),
    .cam_if    (dif)
  );

  int vec_cnt = 0;
  int miscompares = 0;
  int valid_cnt = 0;
  int rst_cycles = 0;
  int rst_run = 0;
  int last_rst_len = 0;
  int valid_in_rst = 0;
  logic [31:0] words[$];

  always @(negedge clk) begin
    if (dif.o_cam_data_valid === 1'b1) begin
      valid_cnt++;
      words.push_back(dif.o_cam_data_32);
      if (dif.o_cam_data_rst === 1'b1) valid_in_rst++;
    end
    if (dif.o_cam_data_rst === 1'b1) begin
      rst_cycles++;
      rst_run++;
    end else if (rst_run != 0) begin
      last_rst_len = rst_run;
      rst_run = 0;
    end
  end

  function automatic logic [7:0] pat(input int l, input int k, input int seed);
    return 8'((l * 37 + k * 5 + seed * 11 + 1) & 255);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dif.i_cam_vsync = 1'b0;
      dif.i_cam_href  = 1'b0;
      dif.i_cam_data  = 8'd0;
    end
  endtask

  task automatic vsync_pulse();
    @(negedge clk); dif.i_cam_vsync = 1'b1;
    @(negedge clk); dif.i_cam_vsync = 1'b1;
    idle(14);
  endtask

  task automatic send_line(input int l, input int npix, input int seed);
    for (int k = 0; k < 2 * npix; k++) begin
      @(negedge clk);
      dif.i_cam_href = 1'b1;
      dif.i_cam_data = pat(l, k, seed);
    end
    idle(4);
  endtask

  task automatic send_frame(input int seed);
    for (int l = 0; l < V; l++) send_line(l, H, seed);
  endtask

  task automatic restart();
    @(negedge clk); rst = 1'b1;
    idle(2);
    rst = 1'b0;
    repeat (SKIP + 1) vsync_pulse();
  endtask

  task automatic test_reset();
    idle(3);
    vec_cnt++; if (dif.o_cam_data_rst !== 1'b0) begin miscompares++; $display("FAIL reset_rst: got %b want 0", dif.o_cam_data_rst); end
    vec_cnt++; if (dif.o_cam_data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", dif.o_cam_data_valid); end
    vec_cnt++; if (dif.o_cam_data_32 !== 32'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0", dif.o_cam_data_32); end
    vec_cnt++; if (dif.o_frame_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_frame_cnt: got %0d want 0", dif.o_frame_cnt); end
    vec_cnt++; if (dif.o_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", dif.o_err); end
    @(negedge clk); rst = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_skip();
    int v0, r0, w0, idx;
    logic [31:0] exp_w, got_w;
    vsync_pulse(); send_frame(1);
    vsync_pulse(); send_frame(2);
    vec_cnt++; if (valid_cnt !== 0) begin miscompares++; $display("FAIL skip_no_valid: got %0d want 0", valid_cnt); end
    vec_cnt++; if (rst_cycles !== 0) begin miscompares++; $display("FAIL skip_no_rst: got %0d want 0", rst_cycles); end
    vsync_pulse();
    vec_cnt++; if (rst_cycles !== RLEN) begin miscompares++; $display("FAIL arm_rst_cycles: got %0d want %0d", rst_cycles, RLEN); end
    vec_cnt++; if (last_rst_len !== RLEN) begin miscompares++; $display("FAIL arm_rst_len: got %0d want %0d", last_rst_len, RLEN); end
    vec_cnt++; if (dif.o_frame_cnt !== 8'd0) begin miscompares++; $display("FAIL arm_frame_cnt: got %0d want 0", dif.o_frame_cnt); end
    v0 = valid_cnt; r0 = rst_cycles; w0 = words.size();
    send_frame(3);
    vec_cnt++; if (valid_cnt - v0 !== V * WPL) begin miscompares++; $display("FAIL frame_valids: got %0d want %0d", valid_cnt - v0, V * WPL); end
    for (int l = 0; l < V; l++) begin
      for (int w = 0; w < WPL; w++) begin
        exp_w = {pat(l, 4 * w, 3), pat(l, 4 * w + 1, 3), pat(l, 4 * w + 2, 3), pat(l, 4 * w + 3, 3)};
        idx = w0 + l * WPL + w;
        got_w = (idx < words.size()) ? words[idx] : 32'hxxxx_xxxx;
        vec_cnt++; if (got_w !== exp_w) begin miscompares++; $display("FAIL frame_word l%0d w%0d: got %h want %h", l, w, got_w, exp_w); end
      end
    end
    vsync_pulse();
    vec_cnt++; if (dif.o_frame_cnt !== 8'd1) begin miscompares++; $display("FAIL frame_cnt_after: got %0d want 1", dif.o_frame_cnt); end
    vec_cnt++; if (dif.o_err !== 1'b0) begin miscompares++; $display("FAIL frame_err: got %b want 0", dif.o_err); end
    vec_cnt++; if (rst_cycles - r0 !== RLEN) begin miscompares++; $display("FAIL capture_rst_cycles: got %0d want %0d", rst_cycles - r0, RLEN); end
    $display("test_skip: done");
  endtask

  task automatic test_packing();
    logic [7:0] pkt [16];
    pkt = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 4) begin
        vec_cnt++; if (dif.o_cam_data_valid !== 1'b0) begin miscompares++; $display("FAIL pack_early_valid: got %b want 0", dif.o_cam_data_valid); end
      end
      if (i == 5) begin
        vec_cnt++; if (dif.o_cam_data_valid !== 1'b1) begin miscompares++; $display("FAIL pack_w0_valid: got %b want 1", dif.o_cam_data_valid); end
        vec_cnt++; if (dif.o_cam_data_32 !== 32'h12345678) begin miscompares++; $display("FAIL pack_w0_data: got %h want 12345678", dif.o_cam_data_32); end
      end
      if (i == 6) begin
        vec_cnt++; if (dif.o_cam_data_valid !== 1'b0) begin miscompares++; $display("FAIL pack_single_cycle: got %b want 0", dif.o_cam_data_valid); end
        vec_cnt++; if (dif.o_cam_data_32 !== 32'h12345678) begin miscompares++; $display("FAIL pack_hold: got %h want 12345678", dif.o_cam_data_32); end
      end
      if (i == 9) begin
        vec_cnt++; if (dif.o_cam_data_valid !== 1'b1) begin miscompares++; $display("FAIL pack_w1_valid: got %b want 1", dif.o_cam_data_valid); end
        vec_cnt++; if (dif.o_cam_data_32 !== 32'hABCDEF01) begin miscompares++; $display("FAIL pack_w1_data: got %h want abcdef01", dif.o_cam_data_32); end
      end
      dif.i_cam_href = (i < 16);
      dif.i_cam_data = (i < 16) ? pkt[i] : 8'd0;
    end
    idle(2);
    for (int l = 1; l < V; l++) send_line(l, H, 4);
    vsync_pulse();
    vec_cnt++; if (dif.o_frame_cnt !== 8'd2) begin miscompares++; $display("FAIL pack_frame_cnt: got %0d want 2", dif.o_frame_cnt); end
    vec_cnt++; if (dif.o_err !== 1'b0) begin miscompares++; $display("FAIL pack_err: got %b want 0", dif.o_err); end
    $display("test_packing: done");
  endtask

  task automatic test_long_line();
    int v0;
    restart();
    vec_cnt++; if (dif.o_err !== 1'b0) begin miscompares++; $display("FAIL long_err_pre: got %b want 0", dif.o_err); end
    v0 = valid_cnt;
    send_line(0, H + 1, 5);
    vec_cnt++; if (valid_cnt - v0 !== WPL) begin miscompares++; $display("FAIL long_valids: got %0d want %0d", valid_cnt - v0, WPL); end
    vec_cnt++; if (dif.o_err !== 1'b1) begin miscompares++; $display("FAIL long_err: got %b want 1", dif.o_err); end
    for (int l = 1; l < V; l++) begin
      v0 = valid_cnt;
      send_line(l, H, 5);
      vec_cnt++; if (valid_cnt - v0 !== WPL) begin miscompares++; $display("FAIL long_next_line%0d: got %0d want %0d", l, valid_cnt - v0, WPL); end
    end
    vsync_pulse();
    vec_cnt++; if (dif.o_frame_cnt !== 8'd1) begin miscompares++; $display("FAIL long_frame_cnt: got %0d want 1", dif.o_frame_cnt); end
    $display("test_long_line: done");
  endtask

  task automatic test_odd_line();
    int v0;
    restart();
    vec_cnt++; if (dif.o_err !== 1'b0) begin miscompares++; $display("FAIL odd_err_pre: got %b want 0", dif.o_err); end
    v0 = valid_cnt;
    send_line(0, H - 1, 7);
    vec_cnt++; if (valid_cnt - v0 !== WPL - 1) begin miscompares++; $display("FAIL odd_valids: got %0d want %0d", valid_cnt - v0, WPL - 1); end
    vec_cnt++; if (dif.o_err !== 1'b1) begin miscompares++; $display("FAIL odd_err: got %b want 1", dif.o_err); end
    for (int l = 1; l < V; l++) begin
      v0 = valid_cnt;
      send_line(l, H, 7);
      vec_cnt++; if (valid_cnt - v0 !== WPL) begin miscompares++; $display("FAIL odd_next_line%0d: got %0d want %0d", l, valid_cnt - v0, WPL); end
    end
    $display("test_odd_line: done");
  endtask

  task automatic test_vsync_midline();
    int v0, r0;
    restart();
    vec_cnt++; if (dif.o_err !== 1'b0) begin miscompares++; $display("FAIL mid_err_pre: got %b want 0", dif.o_err); end
    send_line(0, H, 9);
    send_line(1, H, 9);
    v0 = valid_cnt; r0 = rst_cycles;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); dif.i_cam_href = 1'b1; dif.i_cam_data = pat(2, k, 9);
    end
    @(negedge clk); dif.i_cam_vsync = 1'b1; dif.i_cam_href = 1'b1; dif.i_cam_data = 8'hC3;
    @(negedge clk); dif.i_cam_vsync = 1'b1; dif.i_cam_href = 1'b1; dif.i_cam_data = 8'h3C;
    idle(14);
    vec_cnt++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL mid_valids: got %0d want 1", valid_cnt - v0); end
    vec_cnt++; if (dif.o_err !== 1'b1) begin miscompares++; $display("FAIL mid_err: got %b want 1", dif.o_err); end
    vec_cnt++; if (dif.o_frame_cnt !== 8'd1) begin miscompares++; $display("FAIL mid_frame_cnt: got %0d want 1", dif.o_frame_cnt); end
    vec_cnt++; if (rst_cycles - r0 !== RLEN) begin miscompares++; $display("FAIL mid_rst_cycles: got %0d want %0d", rst_cycles - r0, RLEN); end
    v0 = valid_cnt;
    send_frame(11);
    vec_cnt++; if (valid_cnt - v0 !== V * WPL) begin miscompares++; $display("FAIL mid_next_frame: got %0d want %0d", valid_cnt - v0, V * WPL); end
    vsync_pulse();
    vec_cnt++; if (dif.o_frame_cnt !== 8'd2) begin miscompares++; $display("FAIL mid_frame_cnt2: got %0d want 2", dif.o_frame_cnt); end
    $display("test_vsync_midline: done");
  endtask

  task automatic test_reset_midframe();
    int v0, r0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); dif.i_cam_href = 1'b1; dif.i_cam_data = pat(0, k, 12);
    end
    #2 rst = 1'b1;
    #1;
    vec_cnt++; if (dif.o_frame_cnt !== 8'd0) begin miscompares++; $display("FAIL async_frame_cnt: got %0d want 0", dif.o_frame_cnt); end
    vec_cnt++; if (dif.o_err !== 1'b0) begin miscompares++; $display("FAIL async_err: got %b want 0", dif.o_err); end
    vec_cnt++; if (dif.o_cam_data_32 !== 32'd0) begin miscompares++; $display("FAIL async_data: got %h want 0", dif.o_cam_data_32); end
    vec_cnt++; if (dif.o_cam_data_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid: got %b want 0", dif.o_cam_data_valid); end
    vec_cnt++; if (dif.o_cam_data_rst !== 1'b0) begin miscompares++; $display("FAIL async_rst: got %b want 0", dif.o_cam_data_rst); end
    idle(3);
    rst = 1'b0;
    v0 = valid_cnt; r0 = rst_cycles;
    vsync_pulse(); send_frame(13);
    vsync_pulse(); send_frame(14);
    vec_cnt++; if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL rs_skip_valids: got %0d want 0", valid_cnt - v0); end
    vec_cnt++; if (rst_cycles - r0 !== 0) begin miscompares++; $display("FAIL rs_skip_rst: got %0d want 0", rst_cycles - r0); end
    vsync_pulse();
    vec_cnt++; if (rst_cycles - r0 !== RLEN) begin miscompares++; $display("FAIL rs_arm_rst: got %0d want %0d", rst_cycles - r0, RLEN); end
    v0 = valid_cnt;
    send_frame(15);
    vec_cnt++; if (valid_cnt - v0 !== V * WPL) begin miscompares++; $display("FAIL rs_capture_valids: got %0d want %0d", valid_cnt - v0, V * WPL); end
    vsync_pulse();
    vec_cnt++; if (dif.o_frame_cnt !== 8'd1) begin miscompares++; $display("FAIL rs_frame_cnt: got %0d want 1", dif.o_frame_cnt); end
    vec_cnt++; if (dif.o_err !== 1'b0) begin miscompares++; $display("FAIL rs_err: got %b want 0", dif.o_err); end
    $display("test_reset_midframe: done");
  endtask

  initial begin
    dif.i_cam_vsync = 1'b0;
    dif.i_cam_href  = 1'b0;
    dif.i_cam_data  = 8'd0;
    test_reset();
    test_skip();
    test_packing();
    test_long_line();
    test_odd_line();
    test_vsync_midline();
    test_reset_midframe();
    vec_cnt++; if (valid_in_rst !== 0) begin miscompares++; $display("FAIL valid_during_rst: got %0d want 0", valid_in_rst); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule

// File: doc/dvp_capture_pack.md
Name: dvp_capture_pack

Overview:
- Upstream stage of the dual-camera SDRAM frame-buffer path; one instance per OV5640.
- Samples the sensor DVP bus (8-bit, RGB565, two bytes per pixel) and discards the first FRAME_SKIP frames after reset while the sensor settles.
- Packs two pixels into one 32-bit word and emits o_cam_data_valid / o_cam_data_32 / o_cam_data_rst, which drive the camera-side write FIFO and write-address reset of the frame-buffer controller.

Parameters:
- H_ACTIVE, 640, pixels per line accepted; must be even.
- V_ACTIVE, 480, lines per frame accepted.
- FRAME_SKIP, 10, frames discarded after reset (0 = none).
- RST_LEN, 8, o_cam_data_rst pulse length in pclk cycles (covers write-FIFO reset minimum).

Ports:
- i_cam_pclk  in  1  sensor pixel clock; the only clock.
- i_sys_rst  in  1  reset; asynchronous, active-high.
- i_cam_vsync  in  1  sensor vsync, active-high.
- i_cam_href  in  1  sensor line-valid, active-high.
- i_cam_data  in  8  sensor data byte.
- o_cam_data_rst  out  1  frame-start reset pulse to write FIFO / write address.
- o_cam_data_valid  out  1  o_cam_data_32 valid, single-cycle per word.
- o_cam_data_32  out  32  packed word: first pixel [31:16], second pixel [15:0]; each pixel {first byte, second byte}.
- o_frame_cnt  out  8  count of completed captured frames, wraps 255->0.
- o_err  out  1  sticky format error.

Behaviour:
- Reset values: all outputs 0; skip counter 0; state SKIP; all internal counters and registers 0.
- Input stage: vsync, href and data registered once (d1); vsync additionally delayed to d2. vs_rise = d1 & ~d2.
- States:
  - SKIP: count vs_rise. When FRAME_SKIP rises have been seen, go to ARM. If FRAME_SKIP=0, go straight to ARM. No output activity in SKIP.
  - ARM: wait for vs_rise, then go to CAPTURE.
  - CAPTURE: active capture. On vs_rise, increment o_frame_cnt and stay in CAPTURE (new frame).
- o_cam_data_rst:
  - High for exactly RST_LEN cycles, starting the cycle after each vs_rise in ARM or CAPTURE.
  - Never asserted in SKIP.
  - While high, no valid is produced and pixel/line/byte counters are held at 0.
- Byte packing:
  - In CAPTURE, with rst pulse done, each cycle with href_d1=1 captures data_d1 into position byte_idx (0..3, MSB first).
  - When byte_idx=3 is written, o_cam_data_valid=1 on the next cycle with the complete word. Latency: 2 pclk edges from the 4th byte at the pins to valid.
  - o_cam_data_32 holds its value between valids.
- Line handling:
  - href_d1 falling edge ends a line: line_cnt+1, byte_idx and pix_cnt cleared.
  - If byte_idx != 0 or pix_cnt != H_ACTIVE at line end, set o_err and discard the partial word (no valid).
- Cropping:
  - Bytes beyond H_ACTIVE pixels in a line are dropped and o_err is set.
  - Lines with line_cnt >= V_ACTIVE are dropped with no error.
  - Maximum words per frame = H_ACTIVE*V_ACTIVE/2 (153600 at defaults).
- vs_rise while href_d1=1: vsync wins. Partial word discarded, o_err set, new frame started.
- Fewer than V_ACTIVE lines before the next vs_rise: o_err set; frame still counted.
- o_frame_cnt increments on each vs_rise in CAPTURE, i.e. when a frame ends.
- o_err clears only on reset.
- Reset asserted mid-frame: all outputs drop to 0 immediately (async). After release, the block restarts in SKIP with the full FRAME_SKIP count.

Test Plan:
1. FRAME_SKIP=2, 4 well-formed 640x480 frames -> no valid during the first 2 frames. After 3rd vs_rise: rst pulse of 8 cycles. Then 153600 valids for the frame; o_frame_cnt=1 after 4th vs_rise; o_err=0.
2. Line bytes 0x12,0x34,0x56,0x78 -> o_cam_data_32=0x12345678 valid 2 edges after byte 0x78 at pins; next bytes 0xAB,0xCD,0xEF,0x01 -> 0xABCDEF01.
3. One line with 641 pixels -> exactly 320 valids for that line, o_err=1. Later lines produce 320 valids each.
4. Line of 639 pixels (odd) -> 319 valids, trailing half-word dropped, o_err=1.
5. vsync rises mid-line in CAPTURE -> partial word dropped, rst pulse of RST_LEN cycles, o_err=1, o_frame_cnt+1.
6. Reset pulsed mid-frame with FRAME_SKIP=1 -> outputs 0 asynchronously. The next frame after release is skipped; capture resumes at the second vs_rise after release.
